// File: rtl/reflet_rom_prefetch_pkg.sv
// Shared definitions for the Reflet ROM prefetch stage: fetch states, boot defaults and
// header byte selection.
package reflet_rom_prefetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } fetch_state_e;

  localparam logic [31:0] MAGIC_DEFAULT      = 32'h4153524D;
  localparam logic [8:0]  START_ADDR_DEFAULT = 9'h004;

  // Byte 0 of the header is the most significant byte of the magic word.
  function automatic logic [7:0] magic_byte(input logic [31:0] magic, input logic [1:0] idx);
    case (idx)
      2'd0:    return magic[31:24];
      2'd1:    return magic[23:16];
      2'd2:    return magic[15:8];
      default: return magic[7:0];
    endcase
  endfunction

endpackage

// File: rtl/reflet_rom_prefetch_fifo.sv
// Synchronous prefetch FIFO holding {byte, pc} entries; flush empties it in one edge.
module reflet_rom_prefetch_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    full     = (count_q == CNT_W'(DEPTH));
    do_pop   = pop && (count_q != '0);
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign empty     = (count_q == '0);
  assign count     = count_q;

endmodule

// File: rtl/reflet_rom_prefetch.sv
// Reflet fetch stage: boot header check, then ROM streaming into a prefetch FIFO with
// jump redirect. States: IDLE boot | HDR header check | RUN streaming | HALT bad header.
module reflet_rom_prefetch
  import reflet_rom_prefetch_pkg::*;
#(
  parameter int                 ADDR_W       = 9,
  parameter int                 DATA_W       = 8,
  parameter int                 DEPTH        = 4,
  parameter logic [ADDR_W-1:0]  START_ADDR   = START_ADDR_DEFAULT,
  parameter bit                 CHECK_HEADER = 1'b1,
  parameter logic [31:0]        MAGIC        = MAGIC_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_en,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              header_ok,
  output logic              header_err
);

  localparam int ENTRY_W = DATA_W + ADDR_W;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic              inflight_epoch_q, inflight_epoch_d;
  logic              epoch_q, epoch_d;
  logic              header_ok_q, header_ok_d;
  logic              header_err_q, header_err_d;

  logic               issue;
  logic               push;
  logic               pop;
  logic               flush;
  logic [ENTRY_W-1:0] head_data;
  logic               fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;

  always_comb begin
    state_d          = state_q;
    rom_addr_d       = rom_addr_q;
    inflight_d       = 1'b0;
    inflight_pc_d    = inflight_pc_q;
    inflight_epoch_d = inflight_epoch_q;
    epoch_d          = epoch_q;
    header_ok_d      = header_ok_q;
    header_err_d     = header_err_q;
    issue            = 1'b0;
    push             = 1'b0;
    flush            = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (CHECK_HEADER) begin
          state_d = ST_HDR;
        end else begin
          state_d    = ST_RUN;
          rom_addr_d = START_ADDR;
        end
      end
      ST_HDR: begin
        issue = (rom_addr_q < ADDR_W'(4));
        if (inflight_q) begin
          if (rom_data != magic_byte(MAGIC, inflight_pc_q[1:0])) begin
            header_err_d = 1'b1;
            state_d      = ST_HALT;
            issue        = 1'b0;
          end else if (inflight_pc_q[1:0] == 2'd3) begin
            header_ok_d = 1'b1;
            state_d     = ST_RUN;
            rom_addr_d  = START_ADDR;
          end
        end
      end
      ST_RUN: begin
        if (jump) begin
          // Flush and retarget; any return still on the ROM bus belongs to the old epoch.
          flush      = 1'b1;
          epoch_d    = ~epoch_q;
          rom_addr_d = jump_addr;
        end else begin
          push  = inflight_q && (inflight_epoch_q == epoch_q);
          issue = (int'(fifo_count) + int'(inflight_q)) < DEPTH;
        end
      end
      default: ;
    endcase
    if (issue) begin
      rom_addr_d       = rom_addr_q + ADDR_W'(1);
      inflight_d       = 1'b1;
      inflight_pc_d    = rom_addr_q;
      inflight_epoch_d = epoch_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= ST_IDLE;
      rom_addr_q       <= '0;
      inflight_q       <= 1'b0;
      inflight_pc_q    <= '0;
      inflight_epoch_q <= 1'b0;
      epoch_q          <= 1'b0;
      header_ok_q      <= 1'b0;
      header_err_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      rom_addr_q       <= rom_addr_d;
      inflight_q       <= inflight_d;
      inflight_pc_q    <= inflight_pc_d;
      inflight_epoch_q <= inflight_epoch_d;
      epoch_q          <= epoch_d;
      header_ok_q      <= header_ok_d;
      header_err_q     <= header_err_d;
    end
  end

  reflet_rom_prefetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (push),
    .push_data ({rom_data, inflight_pc_q}),
    .pop       (pop),
    .head_data (head_data),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign rom_addr    = rom_addr_q;
  assign rom_en      = (state_q == ST_HDR) || (state_q == ST_RUN);
  assign instr_valid = (state_q == ST_RUN) && !fifo_empty;
  assign pop         = instr_valid && instr_ready;
  assign instr       = instr_valid ? head_data[ENTRY_W-1 -: DATA_W] : '0;
  assign instr_pc    = instr_valid ? head_data[ADDR_W-1:0] : '0;
  assign header_ok   = header_ok_q;
  assign header_err  = header_err_q;

endmodule

// File: tb/tb_reflet_rom_prefetch.sv
// Directed bench for reflet_rom_prefetch around a 512-byte ROM image with the ASRM header.
module tb_reflet_rom_prefetch;

  logic       clk;
  logic       reset;
  logic [8:0] rom_addr;
  logic       rom_en;
  logic [7:0] rom_data;
  logic       jump;
  logic [8:0] jump_addr;
  logic [7:0] instr;
  logic [8:0] instr_pc;
  logic       instr_valid;
  logic       instr_ready;
  logic       header_ok;
  logic       header_err;

  int errors = 0;
  int checks = 0;

  logic [7:0] rom_mem [512];
  logic [7:0] rom_q;
  logic [7:0] boot_bytes [3];

  reflet_rom_prefetch dut (
    .clk         (clk),
    .reset       (reset),
    .rom_addr    (rom_addr),
    .rom_en      (rom_en),
    .rom_data    (rom_data),
    .jump        (jump),
    .jump_addr   (jump_addr),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .header_ok   (header_ok),
    .header_err  (header_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rom_q <= rom_mem[rom_addr];
  assign rom_data = rom_en ? rom_q : 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out_zero(input string tag);
    chk({tag, "_rom_addr"}, 32'(rom_addr), 32'h0);
    chk({tag, "_rom_en"}, 32'(rom_en), 32'h0);
    chk({tag, "_valid"}, 32'(instr_valid), 32'h0);
    chk({tag, "_instr"}, 32'(instr), 32'h0);
    chk({tag, "_pc"}, 32'(instr_pc), 32'h0);
    chk({tag, "_hdr_ok"}, 32'(header_ok), 32'h0);
    chk({tag, "_hdr_err"}, 32'(header_err), 32'h0);
  endtask

  // Release reset mid-cycle; header_ok appears on the 6th negedge, bytes from 004 on the 8th.
  task automatic boot_stream(input string tag);
    int n;
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    while (!header_ok && !header_err && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_hdr_cycles"}, 32'(n), 32'd6);
    chk({tag, "_hdr_ok"}, 32'(header_ok), 32'h1);
    chk({tag, "_rom_en"}, 32'(rom_en), 32'h1);
    @(negedge clk);
    chk({tag, "_pre_valid"}, 32'(instr_valid), 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk({tag, "_boot_valid"}, 32'(instr_valid), 32'h1);
      chk({tag, "_boot_pc"}, 32'(instr_pc), 32'(4 + k));
      chk({tag, "_boot_byte"}, 32'(instr), 32'(boot_bytes[k]));
    end
  endtask

  // Pulse jump from the current negedge; the target byte is valid on the 3rd negedge after.
  task automatic jump_to(input string tag, input logic [8:0] target);
    jump      = 1'b1;
    jump_addr = target;
    @(negedge clk);
    jump = 1'b0;
    chk({tag, "_gap1"}, 32'(instr_valid), 32'h0);
    @(negedge clk);
    chk({tag, "_gap2"}, 32'(instr_valid), 32'h0);
    @(negedge clk);
  endtask

  initial begin
    int n;
    logic [8:0] addr_mid;
    logic seen_valid;
    logic seen_en;

    for (int i = 0; i < 512; i++) rom_mem[i] = 8'((i * 37 + 11) & 255);
    rom_mem[0]     = 8'h41;
    rom_mem[1]     = 8'h53;
    rom_mem[2]     = 8'h52;
    rom_mem[3]     = 8'h4D;
    rom_mem[4]     = 8'h14;
    rom_mem[5]     = 8'h3C;
    rom_mem[6]     = 8'h10;
    rom_mem[9'h0D5] = 8'h7B;
    rom_mem[9'h1FE] = 8'h00;
    rom_mem[9'h1FF] = 8'h00;
    boot_bytes[0] = 8'h14;
    boot_bytes[1] = 8'h3C;
    boot_bytes[2] = 8'h10;

    reset       = 1'b0;
    jump        = 1'b0;
    jump_addr   = '0;
    instr_ready = 1'b1;

    #3;
    chk_out_zero("reset");

    boot_stream("boot");

    // Backpressure: head 006 held while the FIFO fills to 006..009.
    instr_ready = 1'b0;
    addr_mid = '0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 5) addr_mid = rom_addr;
    end
    chk("stall_valid", 32'(instr_valid), 32'h1);
    chk("stall_pc", 32'(instr_pc), 32'h006);
    chk("stall_byte", 32'(instr), 32'h10);
    chk("stall_addr_mid", 32'(addr_mid), 32'h00A);
    chk("stall_addr_end", 32'(rom_addr), 32'h00A);
    instr_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("resume_valid", 32'(instr_valid), 32'h1);
      chk("resume_pc", 32'(instr_pc), 32'(6 + k));
      chk("resume_byte", 32'(instr), 32'(rom_mem[6 + k]));
    end

    // Redirect while a read is in flight and the head is being consumed.
    jump_to("jmp_d5", 9'h0D5);
    chk("jmp_d5_valid", 32'(instr_valid), 32'h1);
    chk("jmp_d5_pc", 32'(instr_pc), 32'h0D5);
    chk("jmp_d5_byte", 32'(instr), 32'h7B);
    @(negedge clk);
    chk("jmp_d6_pc", 32'(instr_pc), 32'h0D6);
    chk("jmp_d6_byte", 32'(instr), 32'(rom_mem[9'h0D6]));

    jump_to("jmp_1fe", 9'h1FE);
    chk("wrap_pc0", 32'(instr_pc), 32'h1FE);
    chk("wrap_byte0", 32'(instr), 32'h00);
    @(negedge clk);
    chk("wrap_pc1", 32'(instr_pc), 32'h1FF);
    chk("wrap_byte1", 32'(instr), 32'h00);
    @(negedge clk);
    chk("wrap_valid2", 32'(instr_valid), 32'h1);
    chk("wrap_pc2", 32'(instr_pc), 32'h000);
    chk("wrap_byte2", 32'(instr), 32'h41);

    // Asynchronous reset away from any clock edge.
    #2;
    reset = 1'b0;
    #1;
    chk_out_zero("midreset");
    repeat (2) @(negedge clk);
    boot_stream("reboot");

    // Corrupted header byte 2: halt on its compare, the 5th negedge after release.
    @(negedge clk);
    reset = 1'b0;
    rom_mem[2] = 8'h00;
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    while (!header_ok && !header_err && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bad_hdr_cycles", 32'(n), 32'd5);
    chk("bad_hdr_err", 32'(header_err), 32'h1);
    chk("bad_hdr_ok", 32'(header_ok), 32'h0);
    chk("bad_rom_en", 32'(rom_en), 32'h0);
    jump       = 1'b1;
    jump_addr  = 9'h004;
    seen_valid = 1'b0;
    seen_en    = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      jump = 1'b0;
      seen_valid = seen_valid | instr_valid;
      seen_en    = seen_en | rom_en;
    end
    chk("halt_valid_seen", 32'(seen_valid), 32'h0);
    chk("halt_en_seen", 32'(seen_en), 32'h0);
    chk("halt_err_sticky", 32'(header_err), 32'h1);
    rom_mem[2] = 8'h52;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
